prism_cfg_loader: RTL and testbench
===================================

Name: prism_cfg_loader

Overview:
- Sequences bulk reconfiguration of the PRISM controller through its 32-bit debug write port.
- Buffers a stream of config words in a small FIFO and halts PRISM (reset held, FSM disabled). It then writes the words to consecutive debug addresses and releases PRISM.
- Shares the debug port with the TinyQV host path. A host write always wins the cycle.

Parameters:
- ADDR_W, 6, debug address width.
- DATA_W, 32, config word width.
- FIFO_DEPTH, 4, config FIFO entries (power of 2, ≥2).
- HALT_CYCLES, 2, cycles reset/disable are held before the first write.
- ADDR_STEP, 4, byte increment between consecutive words.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- host_wr  in  1  host debug write strobe (32-bit write).
- host_addr  in  ADDR_W  host debug address.
- host_wdata  in  DATA_W  host write data.
- cfg_valid  in  1  config word valid.
- cfg_ready  out  1  FIFO can accept a word.
- cfg_data  in  DATA_W  config word.
- cfg_last  in  1  marks final word of the image.
- start  in  1  pulse: begin load sequence.
- start_addr  in  ADDR_W  debug address of first word.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  sticky readback mismatch (only with macro).
- hold_reset  out  1  force PRISM debug_reset.
- hold_disable  out  1  force PRISM fsm_enable low.
- dbg_wr  out  1  debug write strobe to PRISM.
- dbg_addr  out  ADDR_W  debug address to PRISM.
- dbg_wdata  out  DATA_W  debug write data.
- dbg_rdata  in  DATA_W  PRISM debug read data, combinational on dbg_addr; ignored without the macro.

Behaviour:
- Reset: state IDLE, FIFO empty, address register 0, halt counter 0. All outputs 0 except cfg_ready=1.
- Reset mid-sequence aborts it: the FIFO is flushed, holds drop next cycle and no done pulse is produced.
- FIFO: push when cfg_valid & cfg_ready; cfg_ready = !full. Stores {last,data}. Pushes are accepted in every state, so preloading in IDLE is allowed.
- Debug mux: if host_wr=1, dbg_* = host_* that cycle and the loader does not pop. Otherwise dbg_* are driven by the loader.
- IDLE: on start, latch start_addr, clear err and go to HALT.
  - busy=1 from the cycle after start.
  - start is ignored while busy.
- HALT: hold_reset=hold_disable=1. Count HALT_CYCLES cycles, then go to LOAD.
- LOAD:
  - Holds stay asserted.
  - When the FIFO is non-empty and host_wr=0: dbg_wr=1, dbg_addr=addr, dbg_wdata=head, pop, addr += ADDR_STEP modulo 2^ADDR_W (0x3C+4 wraps to 0x00).
  - Empty FIFO: wait indefinitely with no write.
  - Popped word with last=1: go to RELEASE.
  - Throughput: 1 word/cycle.
- RELEASE: hold_reset=0, hold_disable=1 for one cycle, so PRISM leaves reset before it is enabled. Then go to DONE.
- DONE: holds=0, done=1 for one cycle, busy=0, next state IDLE.
- Minimum sequence with HALT_CYCLES=2 and one word preloaded: start at cycle 0; HALT cycles 1–2; write at cycle 3; RELEASE at 4; done at 5.
- Words remaining in the FIFO after last stay queued for the next start.

Optional Feature:
- Macro PRISM_CFG_READBACK_EN.
- When defined, the cycle after each loader write enters VERIFY:
  - dbg_addr = written address, dbg_wr=0.
  - Compare dbg_rdata to the written data. On mismatch set err; err is sticky until the next accepted start.
  - Host writes in VERIFY stall the compare one cycle.
  - Throughput drops to 1 word per 2 cycles. After the last word's VERIFY, go to RELEASE.
- When undefined: no VERIFY state, err tied 0, dbg_rdata unused.

Decomposition:
- Package prism_cfg_pkg: state enum (IDLE, HALT, LOAD, VERIFY, RELEASE, DONE) and the debug word/address width constants.
- Sub-module prism_cfg_fifo: synchronous FIFO with {last,data} entries, push/pop/full/empty and flush on rst.

Test Plan:
- Preload 3 words (0x11,0x22,0x33 with last on 0x33); start with start_addr=0x08 → writes 0x08/0x0C/0x10 on consecutive cycles, holds high throughout, done one cycle after RELEASE.
- start_addr=0x38 with 3 words → addresses 0x38, 0x3C, 0x00 (wrap).
- Host write to 0x18 during LOAD → that cycle dbg_* = host values, loader word delayed one cycle, no word lost or duplicated.
- Start with empty FIFO, feed words 5 cycles later → loader waits in LOAD with no dbg_wr, then completes normally.
- rst asserted mid-LOAD after 1 of 4 words → next cycle IDLE, holds 0, cfg_ready=1, FIFO empty, no done.
- With PRISM_CFG_READBACK_EN, model returns corrupted data for word 2 → err=1 and stays 1 through done; the next start clears it.

Source files
------------

// File: rtl/prism_cfg_pkg.sv
// Shared types and widths for the PRISM config loader.
package prism_cfg_pkg;

  localparam int unsigned DbgAddrW = 6;
  localparam int unsigned DbgDataW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StLoad,
    StVerify,
    StRelease,
    StDone
  } load_state_e;

endpackage

// File: rtl/prism_cfg_fifo.sv
// Small synchronous FIFO holding {last, data} config entries; rst flushes it.
module prism_cfg_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              push_last_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              head_last_o,
  output logic [DATA_W-1:0] head_data_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [IdxW:0]   wr_ptr_q, rd_ptr_q;
  logic [DATA_W:0] mem_q [DEPTH];
  logic            push_en, pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                   (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  assign {head_last_o, head_data_o} = mem_q[rd_ptr_q[IdxW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + (IdxW + 1)'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + (IdxW + 1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[IdxW-1:0]] <= {push_last_i, push_data_i};
  end

endmodule

// File: rtl/prism_cfg_loader.sv
// Bulk PRISM reconfiguration sequencer sharing the debug write port with the host.
// Optional readback verification is enabled by defining PRISM_CFG_READBACK_EN.
module prism_cfg_loader
  import prism_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W      = DbgAddrW,
  parameter int unsigned DATA_W      = DbgDataW,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HALT_CYCLES = 2,
  parameter int unsigned ADDR_STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_last,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              hold_reset,
  output logic              hold_disable,
  output logic              dbg_wr,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_wdata,
  input  logic [DATA_W-1:0] dbg_rdata
);

  localparam int unsigned HaltW = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [HaltW-1:0]  halt_cnt_q, halt_cnt_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic              head_last;
  logic [DATA_W-1:0] head_data;

  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;

`ifdef PRISM_CFG_READBACK_EN
  logic              err_q, err_d;
  logic [ADDR_W-1:0] vaddr_q;
  logic [DATA_W-1:0] vdata_q;
  logic              vlast_q;
`endif

  prism_cfg_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (cfg_valid),
    .push_last_i (cfg_last),
    .push_data_i (cfg_data),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_last_o (head_last),
    .head_data_o (head_data)
  );

  assign cfg_ready = ~fifo_full;

  // Next-state, loader write request and status outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    halt_cnt_d   = halt_cnt_q;
    fifo_pop     = 1'b0;
    ld_wr        = 1'b0;
    ld_addr      = '0;
    ld_wdata     = '0;
    hold_reset   = 1'b0;
    hold_disable = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
`ifdef PRISM_CFG_READBACK_EN
    err_d        = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d     = start_addr;
          halt_cnt_d = '0;
          state_d    = StHalt;
`ifdef PRISM_CFG_READBACK_EN
          err_d      = 1'b0;
`endif
        end
      end
      StHalt: begin
        busy         = 1'b1;
        hold_reset   = 1'b1;
        hold_disable = 1'b1;
        if (halt_cnt_q == HaltW'(HALT_CYCLES - 1)) begin
          halt_cnt_d = '0;
          state_d    = StLoad;
        end else begin
          halt_cnt_d = halt_cnt_q + HaltW'(1);
        end
      end
      StLoad: begin
        busy         = 1'b1;
        hold_reset   = 1'b1;
        hold_disable = 1'b1;
        // Host owns the port this cycle; the loader simply retries next cycle.
        if (!fifo_empty && !host_wr) begin
          ld_wr    = 1'b1;
          ld_addr  = addr_q;
          ld_wdata = head_data;
          fifo_pop = 1'b1;
          addr_d   = addr_q + ADDR_W'(ADDR_STEP);
`ifdef PRISM_CFG_READBACK_EN
          state_d  = StVerify;
`else
          if (head_last) state_d = StRelease;
`endif
        end
      end
      StVerify: begin
`ifdef PRISM_CFG_READBACK_EN
        busy         = 1'b1;
        hold_reset   = 1'b1;
        hold_disable = 1'b1;
        ld_addr      = vaddr_q;
        if (!host_wr) begin
          if (dbg_rdata != vdata_q) err_d = 1'b1;
          state_d = vlast_q ? StRelease : StLoad;
        end
`else
        state_d = StIdle;
`endif
      end
      StRelease: begin
        // PRISM leaves reset one cycle before it is re-enabled.
        busy         = 1'b1;
        hold_disable = 1'b1;
        state_d      = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      halt_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      halt_cnt_q <= halt_cnt_d;
    end
  end

`ifdef PRISM_CFG_READBACK_EN
  // Remember the last loader write so it can be read back next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      vaddr_q <= '0;
      vdata_q <= '0;
      vlast_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (ld_wr) begin
        vaddr_q <= ld_addr;
        vdata_q <= ld_wdata;
        vlast_q <= head_last;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^dbg_rdata;
  assign err          = 1'b0;
`endif

  // Host write always wins the shared debug port.
  always_comb begin
    dbg_wr    = host_wr | ld_wr;
    dbg_addr  = host_wr ? host_addr : ld_addr;
    dbg_wdata = host_wr ? host_wdata : ld_wdata;
  end

endmodule

// File: tb/tb_prism_cfg_loader.sv
// Directed self-checking bench for prism_cfg_loader.
module tb_prism_cfg_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_wr;
  logic [5:0]  host_addr;
  logic [31:0] host_wdata;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;
  logic        cfg_last;
  logic        start;
  logic [5:0]  start_addr;
  logic        busy, done, err, hold_reset, hold_disable, dbg_wr;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Simple PRISM register model for readback; one address can be corrupted.
  logic [31:0] shadow [64];
  logic        corrupt_en = 1'b0;
  assign dbg_rdata = (corrupt_en && dbg_addr == 6'h0C) ? ~shadow[dbg_addr] : shadow[dbg_addr];

  always @(posedge clk) if (dbg_wr) shadow[dbg_addr] <= dbg_wdata;

  always #5 clk = ~clk;

  prism_cfg_loader dut (
    .clk          (clk),
    .rst          (rst),
    .host_wr      (host_wr),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
    .start        (start),
    .start_addr   (start_addr),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .hold_reset   (hold_reset),
    .hold_disable (hold_disable),
    .dbg_wr       (dbg_wr),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_rdata    (dbg_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one cycle of outputs against hand-computed values, then advance.
  task automatic cyc(input string tag, input logic b, input logic w, input logic hr,
                     input logic hd, input logic d, input logic [5:0] a, input logic [31:0] wd);
    #1;
    check(tag, {21'd0, busy, dbg_wr, hold_reset, hold_disable, done, dbg_addr, dbg_wdata},
          {21'd0, b, w, hr, hd, d, a, wd});
    tick();
    start     = 1'b0;
    host_wr   = 1'b0;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic push(input logic [31:0] data, input logic last);
    cfg_valid = 1'b1;
    cfg_data  = data;
    cfg_last  = last;
    #1;
    check("push_ready", {63'd0, cfg_ready}, 64'd1);
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    host_wr    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    cfg_last   = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_ready", {63'd0, cfg_ready}, 64'd1);
    check("rst_err", {63'd0, err}, 64'd0);
    cyc("rst_outs", 0, 0, 0, 0, 0, 6'h00, 32'h0);

`ifndef PRISM_CFG_READBACK_EN
    // Basic three-word image; a second start while busy must be ignored.
    push(32'h11, 0); push(32'h22, 0); push(32'h33, 1);
    start = 1'b1; start_addr = 6'h08;
    cyc("t1_c0_idle", 0, 0, 0, 0, 0, 6'h00, 32'h0);
    start = 1'b1; start_addr = 6'h30;
    cyc("t1_c1_halt", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t1_c2_halt", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t1_c3_w0", 1, 1, 1, 1, 0, 6'h08, 32'h11);
    cyc("t1_c4_w1", 1, 1, 1, 1, 0, 6'h0C, 32'h22);
    cyc("t1_c5_w2", 1, 1, 1, 1, 0, 6'h10, 32'h33);
    cyc("t1_c6_rel", 1, 0, 0, 1, 0, 6'h00, 32'h0);
    cyc("t1_c7_done", 0, 0, 0, 0, 1, 6'h00, 32'h0);
    cyc("t1_c8_idle", 0, 0, 0, 0, 0, 6'h00, 32'h0);
    check("t1_err", {63'd0, err}, 64'd0);

    // Address wrap past the top of the debug space.
    push(32'hA1, 0); push(32'hA2, 0); push(32'hA3, 1);
    start = 1'b1; start_addr = 6'h38;
    cyc("t2_c0", 0, 0, 0, 0, 0, 6'h00, 32'h0);
    cyc("t2_c1", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t2_c2", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t2_w38", 1, 1, 1, 1, 0, 6'h38, 32'hA1);
    cyc("t2_w3c", 1, 1, 1, 1, 0, 6'h3C, 32'hA2);
    cyc("t2_w00", 1, 1, 1, 1, 0, 6'h00, 32'hA3);
    cyc("t2_rel", 1, 0, 0, 1, 0, 6'h00, 32'h0);
    cyc("t2_done", 0, 0, 0, 0, 1, 6'h00, 32'h0);

    // Host write steals one LOAD cycle.
    push(32'hB1, 0); push(32'hB2, 0); push(32'hB3, 1);
    start = 1'b1; start_addr = 6'h00;
    cyc("t3_c0", 0, 0, 0, 0, 0, 6'h00, 32'h0);
    cyc("t3_c1", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t3_c2", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t3_w0", 1, 1, 1, 1, 0, 6'h00, 32'hB1);
    host_wr = 1'b1; host_addr = 6'h18; host_wdata = 32'hDEADBEEF;
    cyc("t3_host", 1, 1, 1, 1, 0, 6'h18, 32'hDEADBEEF);
    cyc("t3_w1", 1, 1, 1, 1, 0, 6'h04, 32'hB2);
    cyc("t3_w2", 1, 1, 1, 1, 0, 6'h08, 32'hB3);
    cyc("t3_rel", 1, 0, 0, 1, 0, 6'h00, 32'h0);
    cyc("t3_done", 0, 0, 0, 0, 1, 6'h00, 32'h0);

    // Start on an empty FIFO; words arrive later.
    start = 1'b1; start_addr = 6'h20;
    cyc("t4_c0", 0, 0, 0, 0, 0, 6'h00, 32'h0);
    cyc("t4_c1", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t4_c2", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t4_wait3", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t4_wait4", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cfg_valid = 1'b1; cfg_data = 32'hC1; cfg_last = 1'b0;
    cyc("t4_wait5", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cfg_valid = 1'b1; cfg_data = 32'hC2; cfg_last = 1'b1;
    cyc("t4_w0", 1, 1, 1, 1, 0, 6'h20, 32'hC1);
    cyc("t4_w1", 1, 1, 1, 1, 0, 6'h24, 32'hC2);
    cyc("t4_rel", 1, 0, 0, 1, 0, 6'h00, 32'h0);
    cyc("t4_done", 0, 0, 0, 0, 1, 6'h00, 32'h0);

    // Reset in the middle of LOAD aborts and flushes.
    push(32'hD1, 0); push(32'hD2, 0); push(32'hD3, 0); push(32'hD4, 1);
    start = 1'b1; start_addr = 6'h00;
    cyc("t5_c0", 0, 0, 0, 0, 0, 6'h00, 32'h0);
    cyc("t5_c1", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t5_c2", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t5_w0", 1, 1, 1, 1, 0, 6'h00, 32'hD1);
    rst = 1'b1;
    cyc("t5_rstcyc", 1, 1, 1, 1, 0, 6'h04, 32'hD2);
    rst = 1'b0;
    #1;
    check("t5_ready", {63'd0, cfg_ready}, 64'd1);
    cyc("t5_idle", 0, 0, 0, 0, 0, 6'h00, 32'h0);
    cyc("t5_nodone", 0, 0, 0, 0, 0, 6'h00, 32'h0);
    // A fresh start must find the FIFO empty.
    start = 1'b1; start_addr = 6'h10;
    cyc("t5_s0", 0, 0, 0, 0, 0, 6'h00, 32'h0);
    cyc("t5_s1", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t5_s2", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t5_empty", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cfg_valid = 1'b1; cfg_data = 32'hE1; cfg_last = 1'b1;
    cyc("t5_empty2", 1, 0, 1, 1, 0, 6'h00, 32'h0);
    cyc("t5_we1", 1, 1, 1, 1, 0, 6'h10, 32'hE1);
    cyc("t5_rel", 1, 0, 0, 1, 0, 6'h00, 32'h0);
    cyc("t5_done", 0, 0, 0, 0, 1, 6'h00, 32'h0);
    check("t5_err", {63'd0, err}, 64'd0);
`else
    begin
      bit seen;
      // Readback with word 2 (address 0x0C) corrupted by the model.
      corrupt_en = 1'b1;
      push(32'h11, 0); push(32'h22, 0); push(32'h33, 1);
      start = 1'b1; start_addr = 6'h08;
      tick();
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        #1;
        if (done) begin
          seen = 1'b1;
          check("rb_err_at_done", {63'd0, err}, 64'd1);
        end
        tick();
      end
      check("rb_done_seen", {63'd0, seen}, 64'd1);
      check("rb_err_after", {63'd0, err}, 64'd1);
      // Next start clears the sticky error.
      corrupt_en = 1'b0;
      push(32'h44, 1);
      start = 1'b1; start_addr = 6'h20;
      tick();
      start = 1'b0;
      #1;
      check("rb_err_clr", {63'd0, err}, 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        #1;
        if (done) begin
          seen = 1'b1;
          check("rb_err_clean", {63'd0, err}, 64'd0);
        end
        tick();
      end
      check("rb_done2_seen", {63'd0, seen}, 64'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
